// File: rtl/sb_timer_pkg.sv
// Shared definitions for the sideband millisecond timers: FSM state encoding,
// default timeout values named by their USB4 meaning, and timeout_sel codes.
package sb_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } tmr_state_e;

    // Default timeouts in milliseconds.
    localparam int unsigned TMO_CMD_RESP_MS    = 10;   // command-response wait
    localparam int unsigned TMO_TRAIN_ABORT_MS = 50;   // training abort
    localparam int unsigned TMO_DISCONNECT_MS  = 100;  // disconnect detection
    localparam int unsigned TMO_MAX_MS         = 255;  // longest supported wait

    // timeout_sel encodings.
    localparam logic [1:0] SEL_CMD_RESP    = 2'd0;
    localparam logic [1:0] SEL_TRAIN_ABORT = 2'd1;
    localparam logic [1:0] SEL_DISCONNECT  = 2'd2;
    localparam logic [1:0] SEL_MAX         = 2'd3;

endpackage

// File: rtl/ms_tick_det.sv
// Rising-edge detector for the ms_clk level produced by ms_clock_div.
// ms_clk is sampled in the sb_clk domain; tick is one sb_clk cycle wide.
// The edge register resets low so a low ms_clk at release gives no tick.
module ms_tick_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic tick_o
);

    logic level_q;

    // Delay ms_clk by one sb_clk cycle for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign tick_o = level_i & ~level_q;

endmodule

// File: rtl/sb_ms_timeout_timer.sv
// Millisecond timeout timer for the USB4 sideband link layer.
// Counts ms_clk rising edges after a start pulse and flags expiry of the
// selected timeout. All outputs are registered.
// Input priority: stop > start > tick. A re-trigger discards a coincident tick.
module sb_ms_timeout_timer
    import sb_timer_pkg::*;
#(
    parameter int          CNT_W = 8,
    parameter int unsigned TMO_0 = TMO_CMD_RESP_MS,
    parameter int unsigned TMO_1 = TMO_TRAIN_ABORT_MS,
    parameter int unsigned TMO_2 = TMO_DISCONNECT_MS,
    parameter int unsigned TMO_3 = TMO_MAX_MS
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             ms_clk,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       timeout_sel,
    output logic             busy,
    output logic             expired,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] elapsed_ms,
    output logic [1:0]       dbg_state
);

    tmr_state_e       state_q;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             expired_q;
    logic             pulse_q;

    logic             tick;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   eff_limit;
    logic [CNT_W-1:0] sel_limit;

    function automatic logic [CNT_W-1:0] tmo_of(input logic [1:0] sel);
        case (sel)
            SEL_CMD_RESP:    return CNT_W'(TMO_0);
            SEL_TRAIN_ABORT: return CNT_W'(TMO_1);
            SEL_DISCONNECT:  return CNT_W'(TMO_2);
            default:         return CNT_W'(TMO_3);
        endcase
    endfunction

    ms_tick_det u_tick (
        .clk_i   (sb_clk),
        .rst_ni  (rst),
        .level_i (ms_clk),
        .tick_o  (tick)
    );

    // One extra bit keeps cnt+1 from wrapping in the compare; a latched
    // limit of 0 is treated as 1 so it expires on the first tick.
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign eff_limit = (limit_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, limit_q};
    assign sel_limit = tmo_of(timeout_sel);

    // Timer FSM with limit, counter and registered status outputs.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            limit_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (stop) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b0;
            end else if (start) begin
                state_q   <= ST_RUN;
                limit_q   <= sel_limit;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                expired_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (tick) begin
                            cnt_q <= cnt_inc[CNT_W-1:0];
                            if (cnt_inc >= eff_limit) begin
                                state_q   <= ST_EXPIRED;
                                busy_q    <= 1'b0;
                                expired_q <= 1'b1;
                                pulse_q   <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign expired       = expired_q;
    assign timeout_pulse = pulse_q;
    assign elapsed_ms    = cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sb_ms_timeout_timer.sv
// Testbench for sb_ms_timeout_timer. A driver applies one input set per
// sb_clk cycle on the falling edge and pushes the reference model's expected
// outputs; a monitor pops and compares one entry after each rising edge.
module tb_sb_ms_timeout_timer;

  localparam int CNT_W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic             sb_clk = 1'b0;
  logic             rst;
  logic             ms_clk;
  logic             start;
  logic             stop;
  logic [1:0]       timeout_sel;
  logic             busy;
  logic             expired;
  logic             timeout_pulse;
  logic [CNT_W-1:0] elapsed_ms;
  logic [1:0]       dbg_state;

  always #5 sb_clk = ~sb_clk;

  sb_ms_timeout_timer #(.CNT_W(CNT_W)) dut (
    .sb_clk        (sb_clk),
    .rst           (rst),
    .ms_clk        (ms_clk),
    .start         (start),
    .stop          (stop),
    .timeout_sel   (timeout_sel),
    .busy          (busy),
    .expired       (expired),
    .timeout_pulse (timeout_pulse),
    .elapsed_ms    (elapsed_ms),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 expired
  int  tmo_tab [4] = '{10, 50, 100, 255};
  int  m_mode;
  int  m_cnt;
  int  m_limit;
  int  m_pulse;
  bit  m_prev_ms;
  int  ms_phase;  // phase of the last driven ms_clk sample, 0..5; high on 3..5

  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [10:0] model_out();
    logic [10:0] r;
    r = {(m_mode == 1), (m_mode == 2), (m_pulse != 0), 8'(m_cnt)};
    return r;
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got busy/exp/pulse/ms=%b/%b/%b/%0d want %b/%b/%b/%0d",
               name, $time, act[10], act[9], act[8], act[7:0],
               exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit st, input bit sp, input logic [1:0] sel);
    bit tk;
    int lim;
    @(negedge sb_clk);
    rst         = 1'b1;
    start       = st;
    stop        = sp;
    timeout_sel = sel;
    ms_phase    = (ms_phase + 1) % 6;
    ms_clk      = (ms_phase >= 3);
    tk          = ms_clk && !m_prev_ms;
    m_prev_ms   = ms_clk;
    m_pulse     = 0;
    if (sp) begin
      m_mode = 0;
      m_cnt  = 0;
    end else if (st) begin
      m_mode  = 1;
      m_limit = tmo_tab[sel];
      m_cnt   = 0;
    end else if (m_mode == 1 && tk) begin
      m_cnt++;
      lim = (m_limit < 1) ? 1 : m_limit;
      if (m_cnt >= lim) begin
        m_mode  = 2;
        m_pulse = 1;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)));
  endtask

  task automatic apply_reset(input int n);
    @(negedge sb_clk);
    rst       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    ms_clk    = 1'b0;
    ms_phase  = 5;
    m_prev_ms = 1'b0;
    m_mode    = 0;
    m_cnt     = 0;
    m_pulse   = 0;
    m_limit   = 0;
    #1 check("reset_immediate", {busy, expired, timeout_pulse, elapsed_ms}, 11'd0);
    exp_q.push_back(11'd0);
    for (int i = 1; i < n; i++) begin
      @(negedge sb_clk);
      exp_q.push_back(11'd0);
    end
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && m_cnt != target; i++)
      cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)));
    if (m_cnt != target) begin
      errors++;
      $display("FAIL wait_%s: count %0d after %0d cycles, wanted %0d", tag, m_cnt, budget, target);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge sb_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {busy, expired, timeout_pulse, elapsed_ms}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    ms_clk      = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    timeout_sel = 2'd0;
    apply_reset(4);

    // 1: 10 ms timeout, hold in EXPIRED, then stop
    cycle(1'b1, 1'b0, 2'd0);
    run_until(10, 200, "t1");
    idle_cycles(20);
    cycle(1'b0, 1'b1, 2'd0);
    idle_cycles(4);

    // 2: 50 ms timeout re-triggered after tick 30
    cycle(1'b1, 1'b0, 2'd1);
    run_until(30, 400, "t2a");
    idle_cycles(2);
    cycle(1'b1, 1'b0, 2'd1);
    run_until(50, 400, "t2b");
    idle_cycles(30);
    cycle(1'b0, 1'b1, 2'd1);

    // 3: start+stop together, from IDLE and from RUN
    cycle(1'b1, 1'b1, 2'd2);
    idle_cycles(2);
    cycle(1'b1, 1'b0, 2'd2);
    run_until(3, 100, "t3");
    cycle(1'b1, 1'b1, 2'd2);
    idle_cycles(8);

    // 4: re-trigger coincident with a tick at elapsed 5
    cycle(1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 200 && !(m_cnt == 5 && ms_phase == 2); i++) cycle(1'b0, 1'b0, 2'd1);
    if (!(m_cnt == 5 && ms_phase == 2)) begin
      errors++;
      $display("FAIL wait_t4: count %0d phase %0d", m_cnt, ms_phase);
    end
    cycle(1'b1, 1'b0, 2'd1);
    idle_cycles(12);
    cycle(1'b0, 1'b1, 2'd0);

    // 5: reset mid-run at elapsed 7, then confirm a clean restart
    cycle(1'b1, 1'b0, 2'd2);
    run_until(7, 200, "t5");
    apply_reset(3);
    idle_cycles(12);
    cycle(1'b1, 1'b0, 2'd0);
    run_until(10, 200, "t5b");
    idle_cycles(6);
    cycle(1'b0, 1'b1, 2'd0);

    // 6: full 255 ms count, then extra ticks
    cycle(1'b1, 1'b0, 2'd3);
    run_until(255, 2000, "t6");
    idle_cycles(30);
    cycle(1'b0, 1'b1, 2'd3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)));
    end

    // drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sb_clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
